// File: rtl/matrix_display_pkg.sv
// Shared types and constants for the LED matrix scan scheduler.
package matrix_display_pkg;

  localparam int NUM_COLS = 3;
  localparam int NUM_ROWS = 7;

  localparam logic SCREEN_WATER      = 1'b0;
  localparam logic SCREEN_IRRIGATION = 1'b1;

  // Column index of the final column in a frame.
  localparam logic [1:0] LAST_COL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // One-hot column enable for a column index; out-of-range indices give all-zero.
  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [1:0] idx);
    logic [NUM_COLS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      if (idx == 2'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/matrix_slot_timer.sv
// Column-slot timer: counts 0..SCAN_DIV-1 and flags the end of the blanking
// gap, the second-to-last slot cycle and the last slot cycle.
module matrix_slot_timer #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_blank_done,
  output logic o_slot_penult,
  output logic o_slot_done
);

  // SCAN_DIV > BLANK_CYCLES >= 1, so SCAN_DIV >= 2 and CW >= 1.
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_PENULT = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Slot counter: cleared while idle, wraps after the last slot cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == SLOT_LAST) r_cnt <= '0;
      else                    r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_blank_done  = i_en && (r_cnt == BLANK_LAST);
  assign o_slot_penult = i_en && (r_cnt == SLOT_PENULT);
  assign o_slot_done   = i_en && (r_cnt == SLOT_LAST);

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Time-multiplexed 7x3 LED matrix scanner: blanks before each column, drives
// one latched column per slot, and alternates water/irrigation screens on
// frame boundaries.
module matrix_scan_scheduler
  import matrix_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int DWELL_FRAMES = 200
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                hold_water,
  input  logic [NUM_ROWS-1:0] water_col_2,
  input  logic [NUM_ROWS-1:0] water_col_1,
  input  logic [NUM_ROWS-1:0] water_col_0,
  input  logic [NUM_ROWS-1:0] irrigation_col_2,
  input  logic [NUM_ROWS-1:0] irrigation_col_1,
  input  logic [NUM_ROWS-1:0] irrigation_col_0,
  output logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] col_sel,
  output logic                screen,
  output logic                frame_tick
);

  localparam int FW = $clog2(DWELL_FRAMES + 1);
  localparam logic [FW-1:0] DWELL_LAST = FW'(DWELL_FRAMES - 1);

  state_t              r_state;
  logic [1:0]          r_col_idx;
  logic [FW-1:0]       r_frame_cnt;
  logic                r_screen;
  logic [NUM_ROWS-1:0] r_rows;
  logic [NUM_COLS-1:0] r_col_sel;
  logic                r_frame_tick;

  logic w_timer_clear;
  logic w_blank_done;
  logic w_slot_penult;
  logic w_slot_done;

  logic [NUM_ROWS-1:0] w_water_cols [NUM_COLS];
  logic [NUM_ROWS-1:0] w_irr_cols   [NUM_COLS];
  logic [NUM_ROWS-1:0] w_src_col;

  assign w_water_cols[0] = water_col_0;
  assign w_water_cols[1] = water_col_1;
  assign w_water_cols[2] = water_col_2;
  assign w_irr_cols[0]   = irrigation_col_0;
  assign w_irr_cols[1]   = irrigation_col_1;
  assign w_irr_cols[2]   = irrigation_col_2;

  // The timer only runs while actively scanning; idle or disable holds it at 0.
  assign w_timer_clear = !enable || (r_state == IDLE);

  matrix_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_clear       (w_timer_clear),
    .i_en          (!w_timer_clear),
    .o_blank_done  (w_blank_done),
    .o_slot_penult (w_slot_penult),
    .o_slot_done   (w_slot_done)
  );

  // Source mux: current screen's pattern for the current column.
  always_comb begin
    w_src_col = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      if (r_col_idx == 2'(k)) begin
        w_src_col = (r_screen == SCREEN_IRRIGATION) ? w_irr_cols[k] : w_water_cols[k];
      end
    end
  end

  // Scan FSM with registered outputs, column index, frame counter and screen select.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_col_idx    <= 2'd0;
      r_frame_cnt  <= '0;
      r_screen     <= SCREEN_WATER;
      r_rows       <= '0;
      r_col_sel    <= '0;
      r_frame_tick <= 1'b0;
    end else if (!enable) begin
      // Drop straight to dark; the selected screen survives a disable.
      r_state      <= IDLE;
      r_col_idx    <= 2'd0;
      r_frame_cnt  <= '0;
      r_rows       <= '0;
      r_col_sel    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      // Tick is pre-decoded one cycle early so it lands on the last DRIVE cycle
      // of column 2 as a registered output.
      r_frame_tick <= (r_state != IDLE) && w_slot_penult && (r_col_idx == LAST_COL);

      unique case (r_state)
        IDLE: begin
          r_state   <= BLANK;
          r_col_idx <= 2'd0;
          r_rows    <= '0;
          r_col_sel <= '0;
        end

        BLANK: begin
          if (w_blank_done) begin
            // Rows and column enable switch on together, so rows are never stale.
            r_state   <= DRIVE;
            r_rows    <= w_src_col;
            r_col_sel <= col_onehot(r_col_idx);
          end
        end

        DRIVE: begin
          if (w_slot_done) begin
            r_state   <= BLANK;
            r_rows    <= '0;
            r_col_sel <= '0;
            if (r_col_idx == LAST_COL) begin
              r_col_idx <= 2'd0;
              // Frame end: screen changes only here, so a frame is never mixed.
              if (hold_water) begin
                r_screen    <= SCREEN_WATER;
                r_frame_cnt <= '0;
              end else if (r_frame_cnt == DWELL_LAST) begin
                r_frame_cnt <= '0;
                r_screen    <= (r_screen == SCREEN_WATER) ? SCREEN_IRRIGATION : SCREEN_WATER;
              end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
              end
            end else begin
              r_col_idx <= r_col_idx + 2'd1;
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_rows    <= '0;
          r_col_sel <= '0;
        end
      endcase
    end
  end

  assign rows       = r_rows;
  assign col_sel    = r_col_sel;
  assign screen     = r_screen;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/matrix_scan_scheduler.md
# matrix_scan_scheduler

Time-multiplexing controller for the 7-row × 3-column LED matrix. It alternates the displayed screen between the water-level and irrigation sources at frame boundaries. Within each frame it scans the three columns one at a time and inserts a blanking gap before each column to prevent ghosting. It replaces the clock-phase gating of the two sources and sits between the screen encoders and the matrix pins.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles per column slot (blank + drive); must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all outputs dark; must be ≥ 1.
- DWELL_FRAMES, 200: frames shown per screen before toggling; must be ≥ 1.

Ports:
- clock  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run scan; low forces IDLE immediately.
- hold_water  in  1  pin the display to the water screen while high.
- water_col_2/1/0  in  7 each  water screen column patterns; bit i = row i.
- irrigation_col_2/1/0  in  7 each  irrigation screen column patterns.
- rows  out  7  row drive for the active column; active high.
- col_sel  out  3  one-hot column enable; col_sel[k] drives column k; all-zero when dark.
- screen  out  1  0 = water, 1 = irrigation.
- frame_tick  out  1  one-cycle pulse on the last cycle of each completed frame.

## Operation
- States:
  - IDLE: outputs dark, counters cleared.
  - BLANK: rows=0, col_sel=0.
  - DRIVE: rows = latched column, col_sel one-hot.
- IDLE → BLANK: when enable=1, starting at column 0.
- BLANK → DRIVE: after BLANK_CYCLES cycles. On the transition, latch the selected screen's column[col_idx] into the row register. rows is stable for the whole DRIVE; source changes mid-slot are ignored.
- DRIVE → BLANK: after SCAN_DIV−BLANK_CYCLES cycles. col_idx advances 0→1→2→0.
- Frame end: on the last DRIVE cycle of column 2.
  - frame_tick=1 for that cycle.
  - frame_cnt increments.
  - If frame_cnt reached DWELL_FRAMES−1: frame_cnt clears and screen toggles, taking effect from the next frame's column 0.
- hold_water=1: at the next frame end, screen is forced to 0 and frame_cnt is held at 0. On release, water is shown for a full DWELL_FRAMES before toggling.
- Screen never changes mid-frame; every frame shows all three columns from one source.
- enable=0 in any state: the next cycle is IDLE, outputs dark, col_idx/frame_cnt/slot counter cleared, screen kept. Re-enable restarts at BLANK, column 0.
- Simultaneous dwell expiry and hold_water=1: hold wins, screen=0.

## Timing
- Reset values (asynchronous): state=IDLE, rows=0, col_sel=0, screen=0, frame_tick=0, all counters 0.
- All outputs registered. col_sel and rows change on the same edge; never one-hot while rows hold stale data.
- Slot = SCAN_DIV cycles; frame = 3·SCAN_DIV cycles; screen period = DWELL_FRAMES·3·SCAN_DIV cycles.
- First DRIVE begins BLANK_CYCLES cycles after the first enable=1 sampled edge.
- Reset mid-DRIVE: outputs dark asynchronously; no partial-slot completion.
- Counter widths: $clog2(SCAN_DIV), $clog2(DWELL_FRAMES+1), 2-bit col_idx. No wrap beyond the terminal values.

## Structure
- Package matrix_display_pkg:
  - state enum {IDLE, BLANK, DRIVE}
  - NUM_COLS=3, NUM_ROWS=7
  - SCREEN_WATER=0, SCREEN_IRRIGATION=1
- Sub-module matrix_slot_timer:
  - free counter with clear and enable
  - outputs blank_done and slot_done strobes
  - parameterised by SCAN_DIV and BLANK_CYCLES
- Top holds the FSM, col_idx, frame_cnt, screen register and row latch with source mux.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYCLES=2, DWELL_FRAMES=2.
- Reset then enable=1, water_col_0/1/2=7'h01/7'h02/7'h04:
  - Cycles 0–1: dark.
  - Cycles 2–7: col_sel=3'b001, rows=7'h01.
  - Then column 1 (rows=7'h02), then column 2 (rows=7'h04).
  - frame_tick on cycle 23.
- Irrigation columns all 7'h7F:
  - Frames 0–1: screen=0.
  - Frame 2: screen=1 with rows=7'h7F.
  - Frame 4: screen=0 again.
- Change water_col_0 to 7'h55 mid-DRIVE of column 0: rows stay 7'h01 until the next column-0 slot, then 7'h55.
- hold_water=1 during an irrigation frame:
  - Next frame screen=0.
  - Stays 0 for 5 frames while held.
  - After release, 2 water frames, then irrigation.
- enable=0 mid-DRIVE of column 1:
  - Next cycle rows=0, col_sel=0.
  - On re-enable, 2 dark cycles, then column 0.
- Assert reset_n=0 asynchronously mid-slot: outputs zero without a clock edge; screen=0.
